tdm_demux_rtl: RTL and testbench

Time-division demultiplexer: the receiving end of a 4:1 select-driven serial mux link. It accepts one serial sample per valid cycle, steers each into its channel slot using an internal slot counter aligned by a frame-start marker, and presents each completed frame as a parallel word. The parallel word is offered on a valid/ready handshake. The block sits downstream of the mux and restores the original parallel data `d`. It also flags loss of frame alignment and output overrun.

---
 rtl/tdm_demux_rtl.sv | 117 +++++++++++
 tb/tb_tdm_demux_rtl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_rtl.sv
// Time-division demultiplexer: steers serial samples into channel slots aligned by
// a frame-start marker and offers each completed frame on a valid/ready handshake.
module tdm_demux_rtl #(
    parameter int unsigned CH = 4,
    parameter int unsigned SW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_valid,
    input  logic          frame_start,
    output logic [CH-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [SW-1:0] slot,
    output logic          sync_err,
    output logic          overrun,
    input  logic          clr_err
);

    localparam int unsigned AW = CH - 1;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_asm;
    logic [SW-1:0]   r_slot;
    logic [CH-1:0]   r_dout;
    logic            r_dout_valid;
    logic            r_sync_err;
    logic            r_overrun;

    logic            w_xfer;
    logic            w_last;
    logic            w_zero;
    logic            w_collect;
    logic            w_complete;
    logic            w_sync_set;
    logic            w_ovr_set;
    logic [CH-1:0]   w_word;

    // Channel CH-1 is never stored: it is taken straight from din when the frame closes.
    assign w_xfer     = r_dout_valid & dout_ready;
    assign w_last     = (r_slot == SW'(CH - 1));
    assign w_zero     = (r_slot == '0);
    assign w_collect  = din_valid & (r_state == COLLECT);
    assign w_complete = w_collect & ~frame_start & w_last;
    assign w_sync_set = w_collect & (frame_start ? ~w_zero : w_zero);
    assign w_ovr_set  = w_complete & r_dout_valid & ~dout_ready;
    assign w_word     = {din, r_asm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_asm        <= '0;
            r_slot       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (frame_start) begin
                            r_asm   <= AW'(din);
                            r_slot  <= SW'(1);
                            r_state <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (frame_start) begin
                            r_asm  <= AW'(din);
                            r_slot <= SW'(1);
                        end else if (w_zero) begin
                            r_state <= HUNT;
                        end else if (w_last) begin
                            r_slot <= '0;
                        end else begin
                            r_asm[r_slot] <= din;
                            r_slot        <= r_slot + SW'(1);
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end

            // A held frame that is not accepted blocks the new one.
            if (w_complete && !w_ovr_set) begin
                r_dout       <= w_word;
                r_dout_valid <= 1'b1;
            end else if (w_xfer) begin
                r_dout_valid <= 1'b0;
            end

            if (w_sync_set)
                r_sync_err <= 1'b1;
            else if (clr_err)
                r_sync_err <= 1'b0;

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign slot       = r_slot;
    assign sync_err   = r_sync_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_tdm_demux_rtl.sv
// Bench for tdm_demux_rtl: directed scenarios plus random traffic against a
// frame-level reference model.
module tb_tdm_demux_rtl;

    localparam int unsigned CH = 4;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din, din_valid, frame_start, dout_ready, clr_err;
    logic [CH-1:0] dout;
    logic          dout_valid;
    logic [SW-1:0] slot;
    logic          sync_err, overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: m_pos = -1 while hunting, else next channel index.
    int       m_pos;
    bit [3:0] m_bits;
    bit [3:0] m_dout;
    bit       m_dv, m_se, m_ov;

    tdm_demux_rtl #(.CH(CH), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .slot(slot), .sync_err(sync_err),
        .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos = -1; m_bits = 0; m_dout = 0; m_dv = 0; m_se = 0; m_ov = 0;
    endtask

    task automatic model_edge(input bit d, input bit v, input bit fs, input bit rdy, input bit clr);
        bit xfer, set_se, set_ov, comp;
        bit [3:0] word;
        xfer = m_dv && rdy; set_se = 0; set_ov = 0; comp = 0; word = 0;
        if (v) begin
            if (m_pos < 0) begin
                if (fs) begin m_bits = 0; m_bits[0] = d; m_pos = 1; end
            end else if (fs) begin
                if (m_pos != 0) set_se = 1;
                m_bits = 0; m_bits[0] = d; m_pos = 1;
            end else if (m_pos == 0) begin
                set_se = 1; m_pos = -1;
            end else begin
                m_bits[m_pos] = d;
                if (m_pos == CH - 1) begin comp = 1; word = m_bits; m_pos = 0; end
                else m_pos++;
            end
        end
        if (comp) begin
            if (m_dv && !rdy) set_ov = 1;
            else begin m_dout = word; m_dv = 1; end
        end else if (xfer) m_dv = 0;
        m_se = set_se ? 1'b1 : (clr ? 1'b0 : m_se);
        m_ov = set_ov ? 1'b1 : (clr ? 1'b0 : m_ov);
    endtask

    task automatic step(input bit d, input bit v, input bit fs, input bit rdy, input bit clr);
        din = d; din_valid = v; frame_start = fs; dout_ready = rdy; clr_err = clr;
        @(posedge clk);
        model_edge(d, v, fs, rdy, clr);
        #1;
    endtask

    task automatic do_reset();
        din = 0; din_valid = 0; frame_start = 0; dout_ready = 0; clr_err = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (dout !== 4'b0000) begin bad++; $display("FAIL reset_dout got=%b exp=0000", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", dout_valid); end
        total++; if (slot !== 2'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        total++; if ({sync_err, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {sync_err, overrun}); end
    endtask

    task automatic test_basic();
        bit [3:0] s;
        s = 4'b1101;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(s[k], 1, k == 0, 1, 0);
            if (k < 3) begin
                total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL basic_early_dv k=%0d got=%b exp=0", k, dout_valid); end
            end
        end
        total++; if (dout !== 4'b1101) begin bad++; $display("FAIL basic_dout got=%b exp=1101", dout); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL basic_dv got=%b exp=1", dout_valid); end
        step(0, 0, 0, 1, 0);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", dout_valid); end
        total++; if ({sync_err, overrun} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {sync_err, overrun}); end
    endtask

    task automatic test_sweep();
        bit [3:0] p;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            p = 4'(n);
            for (int k = 0; k < 4; k++) step(p[k], 1, k == 0, 1, 0);
            total++;
            if (dout !== p || dout_valid !== 1'b1) begin
                bad++; $display("FAIL sweep_frame n=%0d got=%b/%b exp=%b/1", n, dout, dout_valid, p);
            end
        end
        total++; if ({sync_err, overrun} !== 2'b00) begin bad++; $display("FAIL sweep_flags got=%b exp=00", {sync_err, overrun}); end
    endtask

    task automatic test_hunt();
        bit [3:0] s;
        s = 4'b0110;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 1, 0);
            total++;
            if (slot !== 2'd0 || dout_valid !== 1'b0) begin
                bad++; $display("FAIL hunt_discard k=%0d got slot=%0d dv=%b exp slot=0 dv=0", k, slot, dout_valid);
            end
        end
        for (int k = 0; k < 4; k++) step(s[k], 1, k == 0, 1, 0);
        total++; if (dout !== 4'b0110 || dout_valid !== 1'b1) begin bad++; $display("FAIL hunt_frame got=%b/%b exp=0110/1", dout, dout_valid); end
    endtask

    task automatic test_gaps();
        bit [3:0] s;
        s = 4'b1011;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(s[k], 1, k == 0, 1, 0);
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    step(1, 0, 1, 1, 0);
                    total++;
                    if (slot !== 2'(k + 1)) begin bad++; $display("FAIL gap_slot k=%0d got=%0d exp=%0d", k, slot, k + 1); end
                end
            end
        end
        total++; if (dout !== 4'b1011 || dout_valid !== 1'b1) begin bad++; $display("FAIL gap_frame got=%b/%b exp=1011/1", dout, dout_valid); end
    endtask

    task automatic test_misalign();
        do_reset();
        step(0, 1, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        total++; if (sync_err !== 1'b1 || slot !== 2'd1) begin bad++; $display("FAIL misalign_flag got se=%b slot=%0d exp se=1 slot=1", sync_err, slot); end
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        total++; if (dout !== 4'b1001 || dout_valid !== 1'b1) begin bad++; $display("FAIL misalign_frame got=%b/%b exp=1001/1", dout, dout_valid); end
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL misalign_sticky got=%b exp=1", sync_err); end
        step(0, 0, 0, 1, 1);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL misalign_clear got=%b exp=0", sync_err); end
    endtask

    task automatic test_overrun();
        bit [3:0] a, b;
        a = 4'b0011; b = 4'b1100;
        do_reset();
        for (int k = 0; k < 4; k++) step(a[k], 1, k == 0, 0, 0);
        for (int k = 0; k < 4; k++) step(b[k], 1, k == 0, 0, 0);
        total++; if (dout !== 4'b0011 || dout_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold got=%b/%b exp=0011/1", dout, dout_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        step(0, 0, 0, 1, 0);
        total++; if (dout_valid !== 1'b0 || dout !== 4'b0011) begin bad++; $display("FAIL ovr_accept got=%b/%b exp=0011/0", dout, dout_valid); end
        // Clear and a fresh overrun in the same cycle: the set must win.
        for (int k = 0; k < 4; k++) step(a[k], 1, k == 0, 0, 0);
        for (int k = 0; k < 3; k++) step(b[k], 1, k == 0, 0, 0);
        step(b[3], 1, 0, 0, 1);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        step(0, 0, 0, 0, 1);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_reset_midframe();
        bit [3:0] a;
        a = 4'b0101;
        do_reset();
        for (int k = 0; k < 4; k++) step(a[k], 1, k == 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (dout !== 4'b0000 || dout_valid !== 1'b0 || slot !== 2'd0 || sync_err !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL async_reset got dout=%b dv=%b slot=%0d se=%b ov=%b exp all 0", dout, dout_valid, slot, sync_err, overrun);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        total++; if (slot !== 2'd0 || sync_err !== 1'b0) begin bad++; $display("FAIL post_reset_hunt got slot=%0d se=%b exp 0/0", slot, sync_err); end
    endtask

    task automatic test_random();
        bit d, v, fs, rdy, clr;
        logic [1:0] es;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            d   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            fs  = (m_pos <= 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(d, v, fs, rdy, clr);
            es = (m_pos < 0) ? 2'd0 : 2'(m_pos);
            total++;
            if (dout !== m_dout || dout_valid !== m_dv) begin
                bad++; $display("FAIL rand_out i=%0d got=%b/%b exp=%b/%b", i, dout, dout_valid, m_dout, m_dv);
            end
            total++;
            if (slot !== es || sync_err !== m_se || overrun !== m_ov) begin
                bad++; $display("FAIL rand_state i=%0d got slot=%0d se=%b ov=%b exp slot=%0d se=%b ov=%b",
                                i, slot, sync_err, overrun, es, m_se, m_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_hunt();
        test_gaps();
        test_misalign();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
